// File: rtl/imm_instr_encoder_if.sv
// Request channel of the instruction encoder: valid/ready handshake plus the
// raw instruction fields to be packed.
interface imm_instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;

    modport master (
        output in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, opcode, rd, rs1, rs2, funct3, funct7, imm,
        output in_ready
    );
endinterface

// File: rtl/imm_instr_encoder.sv
// Packs RV32I fields and a 32-bit immediate into an instruction word, checks
// the immediate, and writes good words to instruction memory at a rising address.
module imm_instr_encoder #(
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    imm_instr_encoder_if.slave    req,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  err_opcode,
    output logic                  err_range,
    output logic                  err_align,
    output logic                  full
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;

    typedef enum logic [1:0] {IDLE, ENCODE, WRITE} state_t;

    typedef enum logic [6:0] {
        OP_R     = 7'b0110011,
        OP_I     = 7'b0010011,
        OP_LOAD  = 7'b0000011,
        OP_S     = 7'b0100011,
        OP_B     = 7'b1100011,
        OP_J     = 7'b1101111,
        OP_LUI   = 7'b0110111,
        OP_AUIPC = 7'b0010111
    } opcode_t;

    state_t        state_q, state_d;
    logic          handshake;
    logic [6:0]    op_q;
    logic [4:0]    rd_q, rs1_q, rs2_q;
    logic [2:0]    f3_q;
    logic [6:0]    f7_q;
    logic [31:0]   imm_q;
    logic signed [31:0] imm_s;
    logic [31:0]   word;
    logic          bad_op, bad_range, bad_align, bad_any;

    assign handshake = req.in_valid & req.in_ready;
    assign imm_s     = signed'(imm_q);
    assign bad_any   = bad_op | bad_range | bad_align;

    // State register: reset and clear both abandon whatever was captured.
    always_ff @(posedge clk) begin
        if (reset || clear) state_q <= IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = ENCODE;
            ENCODE:  state_d = bad_any ? IDLE : WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The strobe is masked while reset/clear is asserted so an aborted WRITE never reaches memory.
    always_comb begin
        req.in_ready = (state_q == IDLE) & ~full & ~clear;
        imem_we      = (state_q == WRITE) & ~reset & ~clear;
    end

    // NOTE: the captured request is pure datapath; it is only consumed after a handshake, so it needs no reset.
    always_ff @(posedge clk) begin
        if (handshake) begin
            op_q  <= req.opcode;
            rd_q  <= req.rd;
            rs1_q <= req.rs1;
            rs2_q <= req.rs2;
            f3_q  <= req.funct3;
            f7_q  <= req.funct7;
            imm_q <= req.imm;
        end
    end

    always_comb begin
        word      = '0;
        bad_op    = 1'b0;
        bad_range = 1'b0;
        bad_align = 1'b0;
        case (op_q)
            OP_R: word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
            OP_I, OP_LOAD: begin
                word      = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
                bad_range = (imm_s < -2048) || (imm_s > 2047);
            end
            OP_S: begin
                word      = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
                bad_range = (imm_s < -2048) || (imm_s > 2047);
            end
            OP_B: begin
                word      = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                             imm_q[4:1], imm_q[11], op_q};
                bad_range = (imm_s < -4096) || (imm_s > 4094);
                bad_align = imm_q[0];
            end
            OP_J: begin
                word      = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
                bad_range = (imm_s < -1048576) || (imm_s > 1048574);
                bad_align = imm_q[0];
            end
            OP_LUI, OP_AUIPC: begin
                word      = {imm_q[31:12], rd_q, op_q};
                bad_align = |imm_q[11:0];
            end
            default: bad_op = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (reset) begin
            imem_addr  <= ADDR_FIRST;
            imem_wdata <= '0;
            err_opcode <= 1'b0;
            err_range  <= 1'b0;
            err_align  <= 1'b0;
            full       <= 1'b0;
        end else if (clear) begin
            imem_addr  <= ADDR_FIRST;
            err_opcode <= 1'b0;
            err_range  <= 1'b0;
            err_align  <= 1'b0;
            full       <= 1'b0;
        end else begin
            if (state_q == ENCODE) begin
                imem_wdata <= word;
                err_opcode <= err_opcode | bad_op;
                err_range  <= err_range  | bad_range;
                err_align  <= err_align  | bad_align;
            end
            // The last word saturates into full rather than wrapping onto BASE_ADDR.
            if (state_q == WRITE) begin
                if (imem_addr == ADDR_LAST) full      <= 1'b1;
                else                        imem_addr <= imem_addr + 1'b1;
            end
        end
    end
endmodule
